// File: rtl/video_cfg_pkg.sv
// Shared types and constants for the video configuration sequencer.
package video_cfg_pkg;

  localparam int CFG_DATA_W              = 32;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WRITE,
    GAP,
    DONE
  } cfg_state_t;

endpackage

// File: rtl/video_cfg_debounce.sv
// Two-flop synchronizer plus stable-level filter. A new level is accepted
// once the synchronized input has held still for CYCLES consecutive samples;
// fall_o pulses for one cycle on each accepted 1->0 transition.
module video_cfg_debounce
  import video_cfg_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               CYCLES  = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int             CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] last_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             stable;
  logic             accept;

  // Synchronizer flops are left unreset so they track the pin while reset
  // is held; the filter state below starts from RST_VAL.
  always_ff @(posedge clk_i) begin
    s1_q <= raw_i;
    s2_q <= s1_q;
  end

  // Stability counter: reloads on any change, saturates at CNT_LAST.
  always_comb begin
    stable  = (s2_q == last_q);
    accept  = stable && (cnt_q == CNT_LAST) && (s2_q != level_q);
    cnt_d   = cnt_q;
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    level_d = accept ? s2_q : level_q;
    fall_d  = accept ? (level_q & ~s2_q) : '0;
  end

  // Filter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q  <= RST_VAL;
      cnt_q   <= '0;
      level_q <= RST_VAL;
      fall_q  <= '0;
    end else begin
      last_q  <= s2_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/video_cfg_sequencer.sv
// Snapshots the bypass switches and writes one daisy-chain core per slot over
// a shared Avalon-MM address/writedata bus with one-hot write strobes.
// Optional feature macro: VIDEO_CFG_AUTO_APPLY_EN (debounced switch changes
// start a sequence without the key).
//
// Handshake: the cores have no waitrequest, so every asserted cfg_write bit
// is a completed write in that cycle; busy covers LATCH..DONE and done
// pulses for one cycle at the end of a sequence.
module video_cfg_sequencer
  import video_cfg_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int GAP_CYCLES      = 4,
  parameter int CFG_ADDR        = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [NUM_CORES-1:0]  sw_bypass,
  input  logic                  key_apply_n,
  output logic                  cfg_address,
  output logic [CFG_DATA_W-1:0] cfg_writedata,
  output logic [NUM_CORES-1:0]  cfg_write,
  output logic                  busy,
  output logic                  done
);

  localparam int               IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CORES - 1);
  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  cfg_state_t            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [NUM_CORES-1:0]  snapshot_q, snapshot_d;
  logic                  pending_q, pending_d;
  logic [NUM_CORES-1:0]  sw_s1_q, sw_s2_q;
  logic [NUM_CORES-1:0]  cfg_write_q, cfg_write_d;
  logic [CFG_DATA_W-1:0] cfg_wdata_q, cfg_wdata_d;
  logic                  cfg_addr_q, cfg_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  key_level;
  logic                  key_fall;
  logic                  press_evt;
  logic                  auto_evt;
  logic                  leave_idle;
  logic                  slot_end;

  // Key filter: idle level is released (high).
  video_cfg_debounce #(
    .WIDTH   (1),
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL (1'b1)
  ) u_key_db (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .raw_i   (key_apply_n),
    .level_o (key_level),
    .fall_o  (key_fall)
  );

  // An accepted fall always leaves the filtered level low.
  assign press_evt = key_fall && !key_level;

`ifdef VIDEO_CFG_AUTO_APPLY_EN
  logic [NUM_CORES-1:0] sw_level;
  logic [NUM_CORES-1:0] sw_fall;

  video_cfg_debounce #(
    .WIDTH   (NUM_CORES),
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL ('0)
  ) u_sw_db (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .raw_i   (sw_bypass),
    .level_o (sw_level),
    .fall_o  (sw_fall)
  );

  // Only compared while idle, so changes during a sequence wait for IDLE.
  assign auto_evt = (sw_level != snapshot_q) || (|(sw_fall & snapshot_q));
`else
  assign auto_evt = 1'b0;
`endif

  // Switch synchronizer feeding the snapshot; unreset so it is already
  // valid when reset releases and the power-up sequence latches it.
  always_ff @(posedge sys_clk) begin
    sw_s1_q <= sw_bypass;
    sw_s2_q <= sw_s1_q;
  end

  // Next-state logic for the write sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    snapshot_d = snapshot_q;
    leave_idle = 1'b0;
    slot_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q || press_evt || auto_evt) begin
          state_d    = LATCH;
          leave_idle = 1'b1;
        end
      end
      LATCH: begin
        snapshot_d = sw_s2_q;
        idx_d      = '0;
        state_d    = WRITE;
      end
      WRITE: begin
        gap_d = '0;
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
        end else begin
          slot_end = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          slot_end = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // End of a write slot: finish after the last core, else advance.
    if (slot_end) begin
      if (idx_q == IDX_LAST) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = WRITE;
      end
    end
    // Presses while busy collapse into one follow-up request.
    pending_d = leave_idle ? 1'b0 : (pending_q || press_evt);
  end

  // Outputs are registered from next state so they line up with state_q.
  always_comb begin
    cfg_write_d = '0;
    cfg_wdata_d = '0;
    cfg_addr_d  = 1'b0;
    if (state_d == WRITE) begin
      cfg_write_d = NUM_CORES'(1) << idx_d;
      cfg_wdata_d = {{(CFG_DATA_W-1){1'b0}}, snapshot_d[idx_d]};
      cfg_addr_d  = 1'(CFG_ADDR);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; pending resets high to align cores at power-up.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      snapshot_q  <= '0;
      pending_q   <= 1'b1;
      cfg_write_q <= '0;
      cfg_wdata_q <= '0;
      cfg_addr_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      snapshot_q  <= snapshot_d;
      pending_q   <= pending_d;
      cfg_write_q <= cfg_write_d;
      cfg_wdata_q <= cfg_wdata_d;
      cfg_addr_q  <= cfg_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_write     = cfg_write_q;
  assign cfg_writedata = cfg_wdata_q;
  assign cfg_address   = cfg_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Directed bench for video_cfg_sequencer (DEBOUNCE_CYCLES=8, GAP_CYCLES=2,
// NUM_CORES=4). Expected latencies are hand-derived from the input edge.
module tb_video_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sw;
  logic        key_n;
  logic        cfg_address;
  logic [31:0] cfg_writedata;
  logic [3:0]  cfg_write;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  video_cfg_sequencer #(
    .NUM_CORES       (4),
    .DEBOUNCE_CYCLES (8),
    .GAP_CYCLES      (2),
    .CFG_ADDR        (0)
  ) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .sw_bypass     (sw),
    .key_apply_n   (key_n),
    .cfg_address   (cfg_address),
    .cfg_writedata (cfg_writedata),
    .cfg_write     (cfg_write),
    .busy          (busy),
    .done          (done)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: counts strokes and checks the strobe is never multi-hot.
  always @(negedge clk) begin
    if (cfg_write != 4'b0000) begin
      wr_count++;
      check("onehot", {31'b0, $onehot(cfg_write)}, 32'd1);
    end
  end

  // Waits (bounded) for the first write; n = negedges waited.
  task automatic wait_write(input string tag, input int max_cyc, output int n);
    n = 0;
    while (cfg_write == 4'b0000 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (cfg_write == 4'b0000) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Called on the negedge where core 0's write is visible.
  task automatic check_seq(input string tag, input logic [3:0] swv);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_wr"},   {28'b0, cfg_write}, 32'd1 << i);
      check({tag, "_wd"},   cfg_writedata, {31'b0, swv[i]});
      check({tag, "_addr"}, {31'b0, cfg_address}, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        check({tag, "_gap_wr"}, {28'b0, cfg_write}, 32'd0);
        check({tag, "_gap_wd"}, cfg_writedata, 32'd0);
      end
      @(negedge clk);
    end
    check({tag, "_done"},      {31'b0, done}, 32'd1);
    check({tag, "_done_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_done_wr"},   {28'b0, cfg_write}, 32'd0);
    @(negedge clk);
    check({tag, "_done_end"},  {31'b0, done}, 32'd0);
    check({tag, "_busy_end"},  {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int wr0;
    rst_n = 1'b1;
    key_n = 1'b1;
    sw    = 4'b1010;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr",   {28'b0, cfg_write}, 32'd0);
    check("rst_wd",   cfg_writedata, 32'd0);
    check("rst_addr", {31'b0, cfg_address}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    repeat (4) @(negedge clk);

    // Power-up sequence from reset release.
    rst_n = 1'b1;
    wait_write("t1", 20, n);
    check("t1_lat", n, 32'd2);
    check_seq("t1", 4'b1010);

`ifdef VIDEO_CFG_AUTO_APPLY_EN
    // Switch changes alone start sequences once stable.
    sw = 4'b0000;
    wait_write("a1", 40, n);
    check("a1_lat", n, 32'd13);
    check_seq("a1", 4'b0000);
    sw = 4'b0100;
    wait_write("a2", 40, n);
    check("a2_lat", n, 32'd13);
    check_seq("a2", 4'b0100);
    wr0 = wr_count;
    repeat (30) @(negedge clk);
    check("a_quiet", wr_count - wr0, 32'd0);
`else
    // Bouncing key, then a clean press.
    sw = 4'b1111;
    repeat (5) @(negedge clk);
    wr0 = wr_count;
    for (int b = 0; b < 2; b++) begin
      key_n = 1'b0;
      repeat (3) @(negedge clk);
      key_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    check("t2_bounce", wr_count - wr0, 32'd0);
    key_n = 1'b0;
    wait_write("t2", 40, n);
    check("t2_lat", n, 32'd13);
    check_seq("t2", 4'b1111);
    repeat (10) @(negedge clk);
    key_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_writes", wr_count - wr0, 32'd4);

    // Press accepted while the power-up sequence runs: one follow-up only.
    wr0 = wr_count;
    sw    = 4'b0110;
    key_n = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_write("t3a", 20, n);
    check("t3a_lat", n, 32'd2);
    check_seq("t3a", 4'b0110);
    wait_write("t3b", 20, n);
    check("t3b_lat", n, 32'd2);
    check_seq("t3b", 4'b0110);
    key_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_writes", wr_count - wr0, 32'd8);

    // Switch change after core 1 does not disturb the running sequence.
    sw    = 4'b0000;
    key_n = 1'b0;
    wait_write("t4a", 40, n);
    check("t4a_lat", n, 32'd13);
    fork
      check_seq("t4a", 4'b0000);
      begin
        repeat (4) @(negedge clk);
        sw = 4'b1111;
      end
    join
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    key_n = 1'b0;
    wait_write("t4b", 40, n);
    check("t4b_lat", n, 32'd13);
    check_seq("t4b", 4'b1111);
    key_n = 1'b1;
    repeat (12) @(negedge clk);

    // Reset during core 2 write drops outputs at once, then restarts.
    key_n = 1'b0;
    wait_write("t5", 40, n);
    check("t5_lat", n, 32'd13);
    sw = 4'b1010;
    repeat (6) @(negedge clk);
    check("t5_core2", {28'b0, cfg_write}, 32'd4);
    rst_n = 1'b0;
    key_n = 1'b1;
    #1;
    check("t5_rst_wr",   {28'b0, cfg_write}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_wd",   cfg_writedata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_write("t5r", 20, n);
    check("t5r_lat", n, 32'd2);
    check_seq("t5r", 4'b1010);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
